// File: rtl/mem_wait_ctrl_pkg.sv
// Shared constants for the simple computer's memory path: ISA encodings,
// addressing modes and the wait-state controller's state encoding.
package mem_wait_ctrl_pkg;

  localparam int unsigned OPC_W = 4;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h2;
  localparam logic [OPC_W-1:0] OP_JUMP  = 4'h3;
  localparam logic [OPC_W-1:0] OP_CMP   = 4'h4;
  localparam logic [OPC_W-1:0] OP_SL    = 4'h5;
  localparam logic [OPC_W-1:0] OP_SR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_PUSH  = 4'h7;
  localparam logic [OPC_W-1:0] OP_POP   = 4'h8;

  localparam int unsigned AMODE_W = 3;
  localparam logic [AMODE_W-1:0] AM_DIRECT    = 3'd0;
  localparam logic [AMODE_W-1:0] AM_INDIRECT  = 3'd1;
  localparam logic [AMODE_W-1:0] AM_IMMEDIATE = 3'd2;
  localparam logic [AMODE_W-1:0] AM_REGISTER  = 3'd3;
  localparam logic [AMODE_W-1:0] AM_STACK     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10
  } state_e;

  // Wait-state counter covers WAIT_STATES-1 for WAIT_STATES up to 15.
  localparam int unsigned WCNT_W = 4;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_wait_ctrl_array.sv
// Plain DEPTH x DATA_W store: synchronous write, registered read port
// that holds its value between reads and clears on reset.
module mem_array
  import mem_wait_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// Single-port memory front end with request/ready handshake, programmable
// wait states and out-of-range address detection.
module mem_wait_ctrl
  import mem_wait_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              CS,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state;
  logic [WCNT_W-1:0]   wcnt;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_cs;
  logic [DATA_W-1:0]   req_data;
  logic                in_range_c;
  logic                mem_we_c;
  logic                mem_re_c;

  assign in_range_c = addr_in_range(32'(req_addr), DEPTH);
  // Array strobes fire on the edge that leaves ACCESS; reset suppresses the write.
  assign mem_we_c   = rst_n && (state == ST_ACCESS) && in_range_c && req_cs;
  assign mem_re_c   = (state == ST_ACCESS) && in_range_c && !req_cs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      req_addr <= '0;
      req_cs   <= 1'b0;
      req_data <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (EN) begin
            req_addr <= MAR;
            req_cs   <= CS;
            req_data <= data_in;
            busy     <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= ST_ACCESS;
            end else begin
              wcnt  <= WCNT_W'(WAIT_STATES - 1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt == '0) begin
            state <= ST_ACCESS;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        ST_ACCESS: begin
          ready <= 1'b1;
          err   <= !in_range_c;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .addr  (req_addr[IDX_W-1:0]),
    .wdata (req_data),
    .rdata (data_out)
  );

endmodule
